// File: rtl/mat_result_serializer_if.sv
// Element stream from the matrix result serializer to the writeback/host path.
// The master drives the element, the slave returns m_ready.
interface mat_result_serializer_if #(
  parameter int unsigned W_OUT = 32,
  parameter int unsigned N     = 2
);
  localparam int unsigned IDX_W = $clog2(N * N);

  logic             m_valid;
  logic             m_ready;
  logic [W_OUT-1:0] m_data;
  logic [IDX_W-1:0] m_idx;
  logic             m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_idx,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_idx,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/mat_result_serializer.sv
// Captures one N x N product matrix and streams it out row-major, one element per
// handshake, accepting the next matrix on the cycle the last element leaves.
module mat_result_serializer #(
  parameter int unsigned W_OUT = 32,
  parameter int unsigned N     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cen,
  input  logic                               valid_in,
  input  logic [N-1:0][N-1:0][W_OUT-1:0]     result_in,
  output logic                               in_ready,
  output logic                               overflow,
  mat_result_serializer_if.master            m
);

  localparam int unsigned NumElem = N * N;
  localparam int unsigned IDX_W   = $clog2(NumElem);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NumElem - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                            state_q, state_d;
  logic   [IDX_W-1:0]                idx_q, idx_d;
  // Flattened row-major: entry row*N+col matches the packed layout of result_in.
  logic   [NumElem-1:0][W_OUT-1:0]   buf_q, buf_d;
  logic                              overflow_q, overflow_d;

  logic streaming, last, xfer, capture;

  always_comb begin
    streaming = (state_q == StStream);
    last      = streaming && (idx_q == LastIdx);
    xfer      = cen && streaming && m.m_ready;
    in_ready  = cen && (!streaming || (xfer && last));
    capture   = valid_in && in_ready;

    m.m_valid = streaming;
    m.m_data  = buf_q[idx_q];
    m.m_idx   = idx_q;
    m.m_last  = last;
    overflow  = overflow_q;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    overflow_d = overflow_q;

    if (cen) begin
      if (valid_in && !in_ready) begin
        overflow_d = 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            buf_d   = result_in;
            idx_d   = '0;
            state_d = StStream;
          end
        end
        StStream: begin
          if (xfer) begin
            if (!last) begin
              idx_d = idx_q + 1'b1;
            end else if (capture) begin
              buf_d = result_in;
              idx_d = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      buf_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
